// File: rtl/count_step_ctrl.sv
// count_step_ctrl: debounced manual/auto step source driving a mod-MODULUS up/down counter with LED mapping.
module count_step_ctrl #(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 8,
  parameter int DB_CYCLES = 20,
  parameter int AUTO_DIV  = 8
) (
  input  logic             cp,
  input  logic             clr_n,
  input  logic             btn_step,
  input  logic             btn_mode,
  input  logic             sw_dir,
  input  logic             sw_hold,
  output logic [WIDTH-1:0] count,
  output logic             z,
  output logic             auto_mode,
  output logic             step_pulse,
  output logic [15:0]      led_pin
);
  localparam int DW = $clog2(DB_CYCLES);
  localparam int PW = $clog2(AUTO_DIV);
  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
  localparam logic [DW-1:0]    DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [PW-1:0]    PS_LAST = PW'(AUTO_DIV - 1);

  typedef enum logic [1:0] {IDLE, CHK_PRESS, PRESSED, CHK_REL} db_state_t;

  // bit order: {hold, dir, mode, step}
  logic [3:0] sync1, sync2;
  logic [1:0] press;

  always_ff @(posedge cp or negedge clr_n)
    if (!clr_n) {sync2, sync1} <= '0;
    else {sync2, sync1} <= {sync1, sw_hold, sw_dir, btn_mode, btn_step};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_db
      db_state_t       state;
      logic [DW-1:0]   cnt;
      logic            pulse;
      logic            s;
      assign s        = sync2[g];
      assign press[g] = pulse;
      always_ff @(posedge cp or negedge clr_n)
        if (!clr_n) begin
          state <= IDLE;
          cnt   <= '0;
          pulse <= 1'b0;
        end else begin
          pulse <= 1'b0;
          case (state)
            IDLE:      if (s) begin state <= CHK_PRESS; cnt <= '0; end
            CHK_PRESS: if (!s) state <= IDLE;
                       else if (cnt == DB_LAST) begin state <= PRESSED; pulse <= 1'b1; end
                       else cnt <= cnt + 1'b1;
            PRESSED:   if (!s) begin state <= CHK_REL; cnt <= '0; end
            CHK_REL:   if (s) state <= PRESSED;
                       else if (cnt == DB_LAST) state <= IDLE;
                       else cnt <= cnt + 1'b1;
            default:   state <= IDLE;
          endcase
        end
    end
  endgenerate

  logic             step_press, mode_press, dir_s, hold_s;
  logic             tick, req, wrap, tgl;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] nxt;

  assign step_press = press[0];
  assign mode_press = press[1];
  assign dir_s      = sync2[2];
  assign hold_s     = sync2[3];
  assign tick       = auto_mode && presc == PS_LAST;
  // a mode press in the same cycle swallows whatever step was pending
  assign req        = !hold_s && !mode_press && (auto_mode ? tick : step_press);
  assign wrap       = dir_s ? count == '0 : count == MAX;
  assign nxt        = wrap ? (dir_s ? MAX : '0) : (dir_s ? count - 1'b1 : count + 1'b1);

  always_ff @(posedge cp or negedge clr_n)
    if (!clr_n) begin
      count      <= '0;
      z          <= 1'b0;
      step_pulse <= 1'b0;
      auto_mode  <= 1'b0;
      tgl        <= 1'b0;
      presc      <= '0;
    end else begin
      step_pulse <= req;
      z          <= req && wrap;
      if (req) count <= nxt;
      if (req && wrap) tgl <= !tgl;
      if (mode_press) begin
        auto_mode <= !auto_mode;
        presc     <= '0;
      end else if (auto_mode && !hold_s) presc <= tick ? '0 : presc + 1'b1;
    end

  always_comb begin
    led_pin             = '0;
    led_pin[WIDTH-1:0]  = count;
    led_pin[7]          = tgl;
    led_pin[15]         = auto_mode;
  end
endmodule

// File: tb/tb_count_step_ctrl.sv
// tb_count_step_ctrl: directed sequence with hand-derived expectations for count_step_ctrl.
module tb_count_step_ctrl;
  logic        cp = 1'b0;
  logic        clr_n, btn_step, btn_mode, sw_dir, sw_hold;
  logic [2:0]  count;
  logic        z, auto_mode, step_pulse;
  logic [15:0] led_pin;
  int          checks = 0;
  int          errors = 0;
  int          nsp = 0;
  int          nz = 0;

  count_step_ctrl #(.WIDTH(3), .MODULUS(8), .DB_CYCLES(20), .AUTO_DIV(8)) dut (
    .cp(cp), .clr_n(clr_n), .btn_step(btn_step), .btn_mode(btn_mode),
    .sw_dir(sw_dir), .sw_hold(sw_hold), .count(count), .z(z),
    .auto_mode(auto_mode), .step_pulse(step_pulse), .led_pin(led_pin)
  );

  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge cp);
      nsp += int'(step_pulse);
      nz  += int'(z);
    end
  endtask

  task automatic set_btn(input bit m, input logic v);
    if (m) btn_mode = v;
    else btn_step = v;
  endtask

  // press lands on the negedge after which the debounce pulse is visible (23 later)
  task automatic press_hold(input bit m);
    set_btn(m, 1'b1);
    run(23);
  endtask

  task automatic release_btn(input bit m);
    run(6);
    set_btn(m, 1'b0);
    run(30);
  endtask

  initial begin
    clr_n = 1'b0; btn_step = 1'b0; btn_mode = 1'b0; sw_dir = 1'b0; sw_hold = 1'b0;
    run(2);
    chk("rst_count", count, 0);
    chk("rst_z", z, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_auto", auto_mode, 0);
    chk("rst_led", led_pin, 0);
    clr_n = 1'b1;
    run(3);
    nsp = 0; nz = 0;
    for (int p = 0; p < 9; p++) begin
      press_hold(0);
      chk("up_early", step_pulse, 0);
      run(1);
      chk("up_step", step_pulse, 1);
      chk("up_count", count, (p + 1) % 8);
      chk("up_z", z, p == 7);
      release_btn(0);
      chk("up_nsp", nsp, p + 1);
      chk("up_led7", led_pin[7], p >= 7);
    end
    chk("up_nz", nz, 1);
    nsp = 0;
    for (int i = 0; i < 10; i++) begin
      btn_step = 1'b1; run(5);
      btn_step = 1'b0; run(5);
    end
    press_hold(0);
    chk("bounce_none", nsp, 0);
    run(1);
    chk("bounce_step", step_pulse, 1);
    chk("bounce_count", count, 2);
    run(216);
    chk("bounce_norepeat", nsp, 1);
    btn_step = 1'b0;
    run(30);
    sw_dir = 1'b1;
    run(5);
    chk("dir_nochange", count, 2);
    press_hold(0); run(1);
    chk("down1", count, 1);
    release_btn(0);
    press_hold(0); run(1);
    chk("down0", count, 0);
    release_btn(0);
    press_hold(0); run(1);
    chk("down_wrap", count, 7);
    chk("down_wrap_z", z, 1);
    run(1);
    chk("down_z_once", z, 0);
    chk("down_sp_once", step_pulse, 0);
    release_btn(0);
    sw_dir = 1'b0;
    press_hold(0); run(1);
    chk("up_wrap", count, 0);
    chk("up_wrap_z", z, 1);
    release_btn(0);
    press_hold(1);
    chk("mode_early", auto_mode, 0);
    run(1);
    chk("mode_auto", auto_mode, 1);
    chk("mode_led15", led_pin[15], 1);
    chk("mode_nostep", step_pulse, 0);
    chk("mode_count", count, 0);
    btn_mode = 1'b0;
    run(8);
    chk("auto_sp1", step_pulse, 1);
    chk("auto_c1", count, 1);
    run(8);
    chk("auto_c2", count, 2);
    btn_step = 1'b1;
    nsp = 0; nz = 0;
    run(40);
    chk("auto_ignbtn_n", nsp, 5);
    chk("auto_ignbtn_c", count, 7);
    chk("auto_nz", nz, 0);
    btn_step = 1'b0;
    sw_hold = 1'b1;
    nsp = 0;
    run(20);
    sw_hold = 1'b0;
    run(7);
    chk("hold_freeze", nsp, 0);
    chk("hold_count", count, 7);
    run(1);
    chk("hold_resume_sp", step_pulse, 1);
    chk("hold_resume_c", count, 0);
    chk("hold_resume_z", z, 1);
    nsp = 0;
    press_hold(1);
    chk("sim_pre_n", nsp, 2);
    chk("sim_pre_c", count, 2);
    chk("sim_pre_auto", auto_mode, 1);
    run(1);
    chk("sim_auto", auto_mode, 0);
    chk("sim_nostep", step_pulse, 0);
    chk("sim_count", count, 2);
    release_btn(1);
    chk("sim_manual_n", nsp, 2);
    chk("sim_manual_c", count, 2);
    press_hold(1); run(1);
    chk("rst_pre_auto", auto_mode, 1);
    btn_mode = 1'b0;
    run(16);
    chk("rst_pre_c4", count, 4);
    btn_step = 1'b1;
    run(10);
    chk("rst_pre_c5", count, 5);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_z", z, 0);
    chk("arst_step", step_pulse, 0);
    chk("arst_auto", auto_mode, 0);
    chk("arst_led", led_pin, 0);
    run(3);
    chk("arst_hold", count, 0);
    clr_n = 1'b1;
    nsp = 0;
    run(23);
    chk("arst_nopulse", nsp, 0);
    run(1);
    chk("arst_step1", step_pulse, 1);
    chk("arst_count1", count, 1);
    chk("arst_manual", auto_mode, 0);
    btn_step = 1'b0;
    run(30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
